// File: rtl/aes_pipe_sched.sv
// aes_pipe_sched: two-requester arbiter for one fixed-latency AES core.
// Grants by burst, drains before key changes, tags blocks back to issuer.
module aes_pipe_sched #(
  parameter int LAT   = 11,
  parameter int NKB   = 128,
  parameter int BURST = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [127:0]   req0_data,
  input  logic [NKB-1:0] req0_key,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [127:0]   req1_data,
  input  logic [NKB-1:0] req1_key,
  output logic           rsp0_valid,
  output logic           rsp1_valid,
  output logic [127:0]   rsp_data,
  output logic [127:0]   core_in,
  output logic [NKB-1:0] core_key,
  output logic           core_valid_in,
  input  logic [127:0]   core_out,
  input  logic           core_valid_out,
  output logic           busy,
  output logic           err
);

  localparam int IW = $clog2(LAT + 1);
  localparam logic [IW-1:0] IMAX = IW'(LAT);
  localparam logic [7:0] BMAX = 8'(BURST);
  localparam logic [7:0] BLAST = 8'(BURST - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN
  } state_t;

  state_t         state;
  logic           owner;
  logic           sel;
  logic           rr_next;
  logic [7:0]     burst_cnt;
  logic [IW-1:0]  inflight;
  logic [4:0]     idle_cnt;
  logic [LAT-1:0] tag_vld;
  logic [LAT-1:0] tag_id;

  logic           own_valid;
  logic           oth_valid;
  logic [NKB-1:0] oth_key;
  logic           key_eq;
  logic           sw_pend;
  logic           issue;
  logic           early_sw;

  always_comb begin
    own_valid = owner ? req1_valid : req0_valid;
    oth_valid = owner ? req0_valid : req1_valid;
    oth_key   = owner ? req0_key : req1_key;
    key_eq    = (oth_key == core_key);
    sw_pend   = oth_valid &&
                (!own_valid || burst_cnt == BMAX);
  end

  assign req0_ready = (state == RUN) && !owner && !sw_pend;
  assign req1_ready = (state == RUN) && owner && !sw_pend;

  assign issue = (req0_valid && req0_ready) ||
                 (req1_valid && req1_ready);

  // Same-key handover on the burst's last issue keeps the core fed.
  assign early_sw = issue && oth_valid && key_eq &&
                    (burst_cnt == BLAST);

  assign core_valid_in = issue;
  assign core_in = !issue ? '0 :
                   owner ? req1_data : req0_data;
  assign busy = (state != IDLE) || (inflight != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      sel        <= 1'b0;
      rr_next    <= 1'b0;
      burst_cnt  <= '0;
      inflight   <= '0;
      idle_cnt   <= '0;
      tag_vld    <= '0;
      tag_id     <= '0;
      core_key   <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_data   <= '0;
      err        <= 1'b0;
    end else begin
      if (issue && !core_valid_out && inflight != IMAX)
        inflight <= inflight + 1'b1;
      else if (!issue && core_valid_out && inflight != '0)
        inflight <= inflight - 1'b1;

      tag_vld <= {tag_vld[LAT-2:0], issue};
      tag_id  <= {tag_id[LAT-2:0], owner};

      rsp0_valid <= tag_vld[LAT-1] && !tag_id[LAT-1];
      rsp1_valid <= tag_vld[LAT-1] && tag_id[LAT-1];
      if (tag_vld[LAT-1])
        rsp_data <= core_out;
      if (core_valid_out != tag_vld[LAT-1])
        err <= 1'b1;

      case (state)
        IDLE: begin
          idle_cnt <= '0;
          if (req0_valid || req1_valid) begin
            sel   <= rr_next ? req1_valid : !req0_valid;
            state <= LOAD;
          end
        end
        LOAD: begin
          core_key  <= sel ? req1_key : req0_key;
          owner     <= sel;
          rr_next   <= ~sel;
          burst_cnt <= '0;
          idle_cnt  <= '0;
          state     <= RUN;
        end
        RUN: begin
          if (issue && burst_cnt != BMAX)
            burst_cnt <= burst_cnt + 1'b1;
          if (early_sw || (sw_pend && key_eq)) begin
            owner     <= ~owner;
            rr_next   <= owner;
            burst_cnt <= '0;
          end else if (sw_pend) begin
            state <= DRAIN;
          end
          if (!req0_valid && !req1_valid && inflight == '0) begin
            idle_cnt <= idle_cnt + 1'b1;
            if (idle_cnt == 5'd15)
              state <= IDLE;
          end else begin
            idle_cnt <= '0;
          end
        end
        DRAIN: begin
          if (inflight == '0) begin
            sel   <= ~owner;
            state <= LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_pipe_sched.sv
// tb_aes_pipe_sched: directed and random traffic against a toy core.
// Scoreboard predicts tag, data and arrival cycle of every response.
module tb_aes_pipe_sched;

  localparam int LAT   = 11;
  localparam int NKB   = 128;
  localparam int BURST = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           req0_valid, req0_ready;
  logic [127:0]   req0_data;
  logic [NKB-1:0] req0_key;
  logic           req1_valid, req1_ready;
  logic [127:0]   req1_data;
  logic [NKB-1:0] req1_key;
  logic           rsp0_valid, rsp1_valid;
  logic [127:0]   rsp_data;
  logic [127:0]   core_in;
  logic [NKB-1:0] core_key;
  logic           core_valid_in;
  logic [127:0]   core_out;
  logic           core_valid_out;
  logic           busy, err;

  aes_pipe_sched #(.LAT(LAT), .NKB(NKB), .BURST(BURST)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_data(req0_data), .req0_key(req0_key),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_data(req1_data), .req1_key(req1_key),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp_data(rsp_data),
    .core_in(core_in), .core_key(core_key),
    .core_valid_in(core_valid_in),
    .core_out(core_out), .core_valid_out(core_valid_out),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] f(input logic [127:0] d,
                                     input logic [127:0] k);
    return {d[63:0], d[127:64]} ^ k ^
           128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  endfunction

  // Stand-in core: fixed latency, resets with the scheduler.
  logic           inject = 1'b0;
  logic [127:0]   pd [LAT];
  logic [LAT-1:0] pv;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pv <= '0;
    end else begin
      pv <= {pv[LAT-2:0], core_valid_in};
      for (int i = LAT - 1; i > 0; i--) pd[i] <= pd[i-1];
      pd[0] <= f(core_in, core_key);
    end
  end

  assign core_out = pd[LAT-1];
  assign core_valid_out = pv[LAT-1] | inject;

  typedef struct {
    int           n;
    logic [127:0] d;
    int           due;
  } exp_t;

  typedef struct {
    int n;
    int cyc;
  } xfer_t;

  exp_t  q[$];
  xfer_t xl[$];
  int    cyc = 0;
  int    n_rsp0 = 0;
  int    n_rsp1 = 0;
  bit    expect_err = 1'b0;
  int    last_n = -1;
  int    run_len = 0;
  int    last_x = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic x0, x1;
    int   n;
    exp_t e;
    if (!rst) begin
      x0 = req0_valid && req0_ready;
      x1 = req1_valid && req1_ready;
      chk("one_ready", req0_ready && req1_ready, 1'b0);
      chk("vin", core_valid_in, x0 | x1);
      if (x0 || x1) begin
        n = x1 ? 1 : 0;
        chk("core_in", core_in, x1 ? req1_data : req0_data);
        chk("core_key", core_key, x1 ? req1_key : req0_key);
        q.push_back('{n, f(x1 ? req1_data : req0_data,
                           x1 ? req1_key : req0_key),
                      cyc + LAT + 1});
        xl.push_back('{n, cyc});
        if (n == last_n && cyc - last_x < 16) run_len++;
        else run_len = 1;
        last_n = n;
        last_x = cyc;
        if (x1 ? req0_valid : req1_valid)
          chk("burst_len", run_len <= BURST, 1'b1);
      end
      chk("rsp_both", rsp0_valid && rsp1_valid, 1'b0);
      while (q.size() != 0 && q[0].due < cyc) begin
        chk("rsp_missing", q[0].due, cyc);
        void'(q.pop_front());
      end
      if (rsp0_valid || rsp1_valid) begin
        if (rsp0_valid) n_rsp0++;
        if (rsp1_valid) n_rsp1++;
        if (q.size() == 0) begin
          chk("rsp_unexpected", 1'b1, 1'b0);
        end else begin
          e = q.pop_front();
          chk("rsp_id", rsp1_valid, e.n);
          chk("rsp_data", rsp_data, e.d);
          chk("rsp_cycle", cyc, e.due);
        end
      end
      chk("err", err, expect_err);
    end
  end

  logic [127:0] keys [3];

  task automatic drv(input int n, input logic v,
                     input logic [127:0] d,
                     input logic [127:0] k);
    if (n == 0) begin
      req0_valid = v;
      req0_data  = d;
      req0_key   = k;
    end else begin
      req1_valid = v;
      req1_data  = d;
      req1_key   = k;
    end
  endtask

  task automatic idle(input int n);
    if (n == 0) req0_valid = 1'b0;
    else req1_valid = 1'b0;
  endtask

  task automatic send(input int n, input logic [127:0] d,
                      input logic [127:0] k);
    logic rdy;
    int   t;
    drv(n, 1'b1, d, k);
    t = 0;
    do begin
      @(negedge clk);
      rdy = (n == 0) ? req0_ready : req1_ready;
      t++;
    end while (!rdy && t < 3000);
    if (!rdy) chk("send_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic burst(input int n, input int len,
                       input logic [127:0] k);
    for (int i = 0; i < len; i++) send(n, rnd128(), k);
    idle(n);
  endtask

  task automatic wait_quiet();
    int t;
    t = 0;
    while ((busy || q.size() != 0) && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("quiet_timeout", t < 400, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic rand_req(input int n);
    logic [127:0] k;
    k = keys[$urandom_range(0, 2)];
    for (int b = 0; b < 6; b++) begin
      burst(n, $urandom_range(1, 20), k);
      if ($urandom_range(0, 3) == 0) begin
        // Long silence so the old grant is gone before a key change.
        repeat ($urandom_range(40, 60)) @(posedge clk);
        k = keys[$urandom_range(0, 2)];
      end else begin
        repeat ($urandom_range(0, 30)) @(posedge clk);
      end
      #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rsp0"}, rsp0_valid, 1'b0);
    chk({tag, "_rsp1"}, rsp1_valid, 1'b0);
    chk({tag, "_rdata"}, rsp_data, '0);
    chk({tag, "_cin"}, core_in, '0);
    chk({tag, "_ckey"}, core_key, '0);
    chk({tag, "_cvin"}, core_valid_in, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
    chk({tag, "_rdy0"}, req0_ready, 1'b0);
    chk({tag, "_rdy1"}, req1_ready, 1'b0);
  endtask

  initial begin
    int r0, r1, gap, ok;
    logic [127:0] kk;
    keys[0] = 128'h000102030405060708090a0b0c0d0e0f;
    keys[1] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    keys[2] = 128'h603deb1015ca71be2b73aef0857d7781;
    drv(0, 1'b0, '0, '0);
    drv(1, 1'b0, '0, '0);
    rst = 1'b1;
    #2;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // single block
    send(0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, keys[0]);
    idle(0);
    wait_quiet();

    // back-to-back from requester 0 only
    r0 = n_rsp0;
    r1 = n_rsp1;
    burst(0, 3, keys[0]);
    wait_quiet();
    chk("b2b_rsp0", n_rsp0 - r0, 3);
    chk("b2b_rsp1", n_rsp1 - r1, 0);

    // contention, different keys: burst, drain, reload
    xl.delete();
    fork
      burst(0, 10, keys[1]);
      burst(1, 10, keys[2]);
    join
    wait_quiet();
    chk("dk_count", xl.size(), 20);
    if (xl.size() >= 9) begin
      ok = 1;
      for (int i = 1; i < 8; i++)
        if (xl[i].n != xl[0].n || xl[i].cyc != xl[0].cyc + i)
          ok = 0;
      chk("dk_first_burst", ok, 1);
      chk("dk_switch", xl[8].n != xl[0].n, 1'b1);
      gap = xl[8].cyc - xl[7].cyc;
      chk("dk_drain_gap", gap > LAT && gap <= LAT + 4, 1'b1);
    end

    // contention, shared key: alternate every BURST, no bubble
    xl.delete();
    kk = keys[0];
    fork
      burst(0, 24, kk);
      burst(1, 24, kk);
    join
    wait_quiet();
    chk("sk_count", xl.size(), 48);
    ok = 1;
    for (int i = 1; i < xl.size(); i++) begin
      if (xl[i].cyc != xl[i-1].cyc + 1) ok = 0;
      if (xl[i].n != ((i % BURST == 0) ? 1 - xl[i-1].n
                                       : xl[i-1].n)) ok = 0;
    end
    chk("sk_alternate", ok, 1);

    // reset with five blocks in flight
    for (int i = 0; i < 5; i++) send(0, rnd128(), keys[1]);
    idle(0);
    rst = 1'b1;
    q.delete();
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    r0 = n_rsp0;
    r1 = n_rsp1;
    repeat (LAT + 6) @(posedge clk);
    #1;
    chk("stale_rsp", (n_rsp0 - r0) + (n_rsp1 - r1), 0);
    send(1, rnd128(), keys[2]);
    idle(1);
    wait_quiet();
    chk("post_rst_rsp1", n_rsp1 - r1, 1);

    // random traffic
    fork
      rand_req(0);
      rand_req(1);
    join
    wait_quiet();
    chk("rand_drained", q.size(), 0);

    // spurious core output
    inject = 1'b1;
    @(posedge clk);
    #1;
    inject = 1'b0;
    expect_err = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("err_held", err, 1'b1);
    rst = 1'b1;
    expect_err = 1'b0;
    #1;
    chk("err_cleared", err, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
